// File: rtl/prbs_pkg.sv
// prbs_pkg: shared state encoding, channel configuration type and reset constants for prbs_generator_multi.
package prbs_pkg;
    localparam int DEF_MAX_LFSR_LEN = 24;
    localparam int RST_CODE_LEN = 2047;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    typedef struct packed {
        logic [4:0] len;
        logic [DEF_MAX_LFSR_LEN-1:0] taps;
        logic [DEF_MAX_LFSR_LEN-1:0] seed;
        logic gold;
    } cfg_t;
    localparam logic [4:0] RST_LEN = 5'd11;
    localparam logic [DEF_MAX_LFSR_LEN-1:0] RST_TAPS = 'h005;
    localparam logic [DEF_MAX_LFSR_LEN-1:0] RST_SEED = 'h7FF;
    localparam cfg_t RST_CFG = '{len: RST_LEN, taps: RST_TAPS, seed: RST_SEED, gold: 1'b0};
endpackage

// File: rtl/prbs_lfsr_lane.sv
// prbs_lfsr_lane: one programmable-length Fibonacci LFSR that advances P steps per accepted word.
module prbs_lfsr_lane
    import prbs_pkg::*;
#(
    parameter int P = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        adv,
    input  logic [4:0]                  len,
    input  logic [DEF_MAX_LFSR_LEN-1:0] taps,
    input  logic [DEF_MAX_LFSR_LEN-1:0] seed,
    output logic [P-1:0]                chips
);
    localparam int W = DEF_MAX_LFSR_LEN;
    logic [W-1:0] s, s_adv, mask, seed_m;
    // chips reflect the held state, so the word is stable until the lane is advanced
    always_comb begin
        mask = (W'(1) << len) - W'(1);
        seed_m = seed & mask;
        s_adv = s;
        chips = '0;
        for (int i = 0; i < P; i++) begin
            chips[i] = s_adv[0];
            s_adv = ((s_adv >> 1) | (W'(^(s_adv & taps)) << (len - 5'd1))) & mask;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s <= RST_SEED;
        else if (load) s <= (seed_m == '0) ? mask : seed_m;
        else if (adv) s <= s_adv;
    end
endmodule

// File: rtl/prbs_generator_multi.sv
// prbs_generator_multi: NUM_CH parallel PRBS channels with run/burst control and code-length tracking.
// Define PRBS_GOLD_EN to add a secondary LFSR per channel for Gold-code output.
module prbs_generator_multi
    import prbs_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int PARALLEL_WIDTH = 8,
    parameter int MAX_LFSR_LEN   = DEF_MAX_LFSR_LEN,
    parameter int COUNTER_WIDTH  = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_load,
    input  logic [$clog2(NUM_CH)-1:0]        cfg_ch,
    input  logic                             cfg_sel,
    input  logic [4:0]                       cfg_len,
    input  logic [MAX_LFSR_LEN-1:0]          cfg_taps,
    input  logic [MAX_LFSR_LEN-1:0]          cfg_seed,
    input  logic                             cfg_gold,
    input  logic [COUNTER_WIDTH-1:0]         cfg_code_len,
    input  logic                             start,
    input  logic                             stop,
    input  logic [COUNTER_WIDTH-1:0]         burst_len,
    input  logic                             out_ready,
    output logic [NUM_CH*PARALLEL_WIDTH-1:0] prbs_out,
    output logic                             prbs_valid,
    output logic [COUNTER_WIDTH-1:0]         chip_count,
    output logic                             sequence_wrap,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err
);
    localparam int LW = DEF_MAX_LFSR_LEN;
    localparam int P = PARALLEL_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] PW = COUNTER_WIDTH'(PARALLEL_WIDTH);

    state_t state, state_nxt;
    cfg_t pri_cfg [NUM_CH];
    cfg_t wr_cfg;
    logic [COUNTER_WIDTH-1:0] code_len, burst, words, code_eff, sum;
    logic [NUM_CH*P-1:0] word;
    logic hs, wrap, last, sel_ok, bad_len, wr_ok;

    assign prbs_valid = state == RUN;
    assign busy = state != IDLE;
    assign hs = prbs_valid && out_ready;
    assign code_eff = code_len < PW ? PW : code_len;
    assign sum = chip_count + PW;
    assign wrap = sum >= code_eff;
    assign last = burst != '0 && words + COUNTER_WIDTH'(1) == burst;
    assign sequence_wrap = prbs_valid && wrap;
    assign prbs_out = prbs_valid ? word : '0;
`ifdef PRBS_GOLD_EN
    assign sel_ok = 1'b1;
`else
    assign sel_ok = !cfg_sel;
`endif
    assign bad_len = cfg_len < 5'd2 || cfg_len > 5'(MAX_LFSR_LEN);
    assign wr_ok = cfg_load && sel_ok && !busy && !bad_len;
    assign wr_cfg = '{len: cfg_len, taps: LW'(cfg_taps), seed: LW'(cfg_seed), gold: cfg_gold};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (start && !stop) ? LOAD : IDLE;
            LOAD:    state_nxt = RUN;
            RUN:     state_nxt = (stop || (hs && last)) ? IDLE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            chip_count <= '0;
            words <= '0;
            burst <= '0;
            code_len <= COUNTER_WIDTH'(RST_CODE_LEN);
            done <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_nxt;
            done <= hs && last && !stop;
            cfg_err <= cfg_load && sel_ok && (busy || bad_len);
            if (state == IDLE && start) burst <= burst_len;
            if (state == LOAD) begin
                chip_count <= '0;
                words <= '0;
            end else if (hs) begin
                chip_count <= wrap ? sum - code_eff : sum;
                words <= words + COUNTER_WIDTH'(1);
            end
            if (wr_ok) code_len <= cfg_code_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) pri_cfg[i] <= RST_CFG;
        end else if (wr_ok && !cfg_sel) begin
            pri_cfg[cfg_ch] <= wr_cfg;
        end
    end

`ifdef PRBS_GOLD_EN
    cfg_t sec_cfg [NUM_CH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) sec_cfg[i] <= RST_CFG;
        end else if (wr_ok && cfg_sel) begin
            sec_cfg[cfg_ch] <= wr_cfg;
        end
    end
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [P-1:0] pri_chips;
        prbs_lfsr_lane #(.P(P)) u_pri (
            .clk(clk), .rst_n(rst_n), .load(state == LOAD), .adv(hs),
            .len(pri_cfg[k].len), .taps(pri_cfg[k].taps), .seed(pri_cfg[k].seed), .chips(pri_chips)
        );
`ifdef PRBS_GOLD_EN
        logic [P-1:0] sec_chips;
        logic unused_sec_gold;
        prbs_lfsr_lane #(.P(P)) u_sec (
            .clk(clk), .rst_n(rst_n), .load(state == LOAD), .adv(hs),
            .len(sec_cfg[k].len), .taps(sec_cfg[k].taps), .seed(sec_cfg[k].seed), .chips(sec_chips)
        );
        assign unused_sec_gold = sec_cfg[k].gold;
        assign word[k*P +: P] = pri_cfg[k].gold ? pri_chips ^ sec_chips : pri_chips;
`else
        logic unused_gold;
        assign unused_gold = pri_cfg[k].gold;
        assign word[k*P +: P] = pri_chips;
`endif
    end
endmodule

// File: doc/prbs_generator_multi.md
PRBS_GENERATOR_MULTI -- requirements
Module: prbs_generator_multi

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent PRBS channels.
REQ-002 Parameter PARALLEL_WIDTH, default 8, SHALL set the chips emitted per channel per accepted word.
REQ-003 Parameter MAX_LFSR_LEN, default 24, SHALL set the maximum programmable LFSR length.
REQ-004 Parameter COUNTER_WIDTH, default 24, SHALL set the width of chip_count, cfg_code_len and burst_len.
REQ-005 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-006 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 cfg_load  in  1  SHALL be the one-cycle strobe that writes the channel configuration.
REQ-008 cfg_ch  in  $clog2(NUM_CH)  SHALL select the channel that is written.
REQ-009 cfg_sel  in  1  SHALL select the LFSR that is written: 0 = primary, 1 = secondary.
REQ-010 cfg_len  in  5  SHALL set the LFSR length L, valid range 2..MAX_LFSR_LEN.
REQ-011 cfg_taps / cfg_seed  in  MAX_LFSR_LEN  SHALL be the feedback tap mask and the seed.
REQ-012 cfg_gold  in  1  SHALL be the per-channel Gold-combine enable.
REQ-013 cfg_code_len  in  COUNTER_WIDTH  SHALL be the global code length in chips.
REQ-014 start / stop  in  1  SHALL be the run-control strobes.
REQ-015 burst_len  in  COUNTER_WIDTH  SHALL be the number of words per run; 0 = continuous.
REQ-016 out_ready  in  1  SHALL be the downstream ready signal.
REQ-017 prbs_out  out  NUM_CH*PARALLEL_WIDTH  SHALL carry the chip word; channel k occupies bits [k*P +: P], and chip 0 is the LSB.
REQ-018 prbs_valid  out  1  SHALL qualify prbs_out.
REQ-019 chip_count  out  COUNTER_WIDTH  SHALL give the chip index of the current word's chip 0.
REQ-020 sequence_wrap  out  1  SHALL flag that the current word crosses or reaches the code length.
REQ-021 busy / done / cfg_err  out  1  SHALL be high while running / pulse at burst completion / pulse on a rejected write.

Function
REQ-022 The state machine SHALL have states IDLE, LOAD and RUN, with transitions:
- IDLE to LOAD on start.
- LOAD to RUN after exactly 1 cycle.
- RUN to IDLE on stop, or on the last burst handshake.
REQ-023 When start and stop are high together, stop SHALL win: stay in IDLE, or go from RUN to IDLE.
REQ-024 start SHALL be ignored while the block is in LOAD or RUN.
REQ-025 LOAD SHALL copy each channel's stored seed into its working LFSR and SHALL clear chip_count and the word counter.
REQ-026 Any seed that is zero within its L bits SHALL be replaced by all-ones across those L bits.
REQ-027 Per LFSR step: output chip = s[0]; fb = XOR-reduction of (s AND taps); s_next = (s >> 1) with fb placed at bit L-1; bits at or above L SHALL stay 0.
REQ-028 Each LFSR SHALL advance exactly PARALLEL_WIDTH steps per word, combinationally within one cycle.
REQ-029 The first word SHALL appear with prbs_valid=1 in the first RUN cycle.
REQ-030 A handshake SHALL be valid AND ready.
REQ-031 While valid is high and ready is low, prbs_out, chip_count and sequence_wrap SHALL stay stable.
REQ-032 On a handshake, the next word SHALL be presented in the following cycle, giving one word per cycle under continuous ready.
REQ-033 sequence_wrap SHALL equal (chip_count + P >= cfg_code_len) for the presented word.
REQ-034 On the handshake of a wrapping word, chip_count SHALL become chip_count + P - cfg_code_len; otherwise it SHALL become chip_count + P.
REQ-035 A cfg_code_len value below P SHALL be treated as P.
REQ-036 For burst_len = N > 0, the block SHALL perform exactly N handshakes, then return to IDLE and pulse done for 1 cycle.
REQ-037 stop in RUN SHALL abort the run: prbs_valid drops the next cycle, even if the current word was not accepted, and done SHALL NOT pulse.
REQ-038 cfg_load while busy SHALL leave the configuration unchanged and pulse cfg_err.
REQ-039 cfg_load with cfg_len out of range SHALL also be rejected and pulse cfg_err.
REQ-040 All arithmetic SHALL be unsigned COUNTER_WIDTH with no overflow beyond wrap subtraction.

Reset
REQ-041 Asserting rst_n SHALL force:
- state to IDLE.
- prbs_valid, busy, done, cfg_err and sequence_wrap to 0.
- chip_count and prbs_out to 0.
- every seed and working LFSR to all-ones, with taps 0x005, L = 11 and gold = 0.
- cfg_code_len to 2047.
REQ-042 Reset mid-RUN SHALL take effect immediately (asynchronous), and no partial word SHALL be emitted after deassertion.

Configuration
REQ-043 With PRBS_GOLD_EN defined, each channel SHALL hold a secondary LFSR, and when gold = 1 its output bits SHALL be the primary chips XOR the secondary chips.
REQ-044 With PRBS_GOLD_EN undefined:
- no secondary LFSR exists.
- writes with cfg_sel = 1 SHALL be ignored without cfg_err.
- cfg_gold SHALL be ignored.
- output SHALL be primary only.

Structure
REQ-045 Package prbs_pkg SHALL hold the state enum, the MAX_LFSR_LEN default, the reset-tap/seed/length constants and the channel configuration struct {len, taps, seed, gold}.
REQ-046 Sub-module prbs_lfsr_lane SHALL implement one LFSR with a P-step advance; it is instantiated per channel, and a second time per channel when PRBS_GOLD_EN is defined.

Verification
REQ-047 Directed scenarios:
- Ch0: L=11, taps=0x005, seed=0x7FF, burst 0, ready high -> first word 0xFF; chip stream has period 2047; sequence_wrap on the 256th word; chip_count = 1 afterwards.
- Ready low for 5 cycles mid-run -> prbs_out and chip_count are unchanged for those 5 cycles; the stream resumes with no missing chip.
- burst_len=3 -> exactly 3 handshakes, then done pulses for 1 cycle and busy falls the same cycle.
- Seed 0, L=5, taps=0x05 -> working LFSR loads 0x1F; the stream has period 31.
- cfg_load while busy -> cfg_err pulses and the configuration is unchanged after restart. Start+stop together in IDLE -> stays IDLE.
- PRBS_GOLD_EN: primary taps 0x005, secondary taps 0x125, both seeds 0x7FF, gold=1 -> output equals the XOR of two standalone runs. Reset mid-RUN -> all outputs go to 0 immediately.
